bin_th_ctrl: RTL and testbench

//  Frame-adaptive threshold controller for the gray-to-binary stage. Watches the same
//  8-bit gray sop/eop/vld stream that feeds the binarizer and accumulates pixel sum and

---
 rtl/bin_th_ctrl.sv | 137 +++++++++++++
 tb/tb_bin_th_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_th_ctrl.sv
// Frame-adaptive binarizer threshold: accumulates per-frame pixel sum/count, serially divides
// at end of frame, and loads the mean (+ offset, saturated) or a manual value. Optional macro BIN_TH_IIR_EN.
module bin_th_ctrl #(
    parameter int                 CNT_W   = 20,
    parameter logic        [7:0]  TH_INIT = 8'd100,
    parameter logic signed [8:0]  TH_OFS  = 9'sd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic       din_vld,
    input  logic [7:0] din,
    input  logic       cfg_auto,
    input  logic [7:0] cfg_th,
    output logic [7:0] th_out,
    output logic       th_upd,
    output logic       busy,
    output logic       seq_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, LOAD} state_t;

    state_t             state;
    logic [CNT_W+7:0]   sum;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         quo;

    logic [CNT_W+7:0]   div_sub;
    logic               div_ge;
    logic [9:0]         ofs_sum;
    logic [7:0]         sat_th;
    logic [7:0]         auto_th;
    logic               frame_start;

    // During DIV, sum doubles as the running remainder of the restoring divider.
    assign div_sub     = {8'd0, cnt} << bit_idx;
    assign div_ge      = (sum >= div_sub);
    assign frame_start = din_vld & din_sop;

    // Mean is at most 255, so a 10-bit two's-complement sum covers -256..511.
    assign ofs_sum = {2'b00, quo} + {TH_OFS[8], TH_OFS};
    assign sat_th  = ofs_sum[9] ? 8'd0 : (ofs_sum[8] ? 8'd255 : ofs_sum[7:0]);

`ifdef BIN_TH_IIR_EN
    logic [9:0] iir_sum;
    assign iir_sum = {2'b00, th_out} + {1'b0, th_out, 1'b0} + {2'b00, sat_th};
    assign auto_th = iir_sum[9:2];
`else
    assign auto_th = sat_th;
`endif

    // A sop&eop on the same beat is a one-pixel frame and goes straight to the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sum     <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            quo     <= '0;
            th_out  <= TH_INIT;
            th_upd  <= 1'b0;
            busy    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            th_upd  <= 1'b0;
            seq_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        sum     <= {{CNT_W{1'b0}}, din};
                        cnt     <= CNT_W'(1);
                        bit_idx <= 3'd7;
                        state   <= din_eop ? DIV : ACCUM;
                        busy    <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (frame_start) begin
                        seq_err <= 1'b1;
                        sum     <= {{CNT_W{1'b0}}, din};
                        cnt     <= CNT_W'(1);
                        bit_idx <= 3'd7;
                        state   <= din_eop ? DIV : ACCUM;
                    end else if (din_vld) begin
                        sum     <= sum + {{CNT_W{1'b0}}, din};
                        cnt     <= cnt + CNT_W'(1);
                        bit_idx <= 3'd7;
                        if (din_eop) begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (frame_start) begin
                        seq_err <= 1'b1;
                        sum     <= {{CNT_W{1'b0}}, din};
                        cnt     <= CNT_W'(1);
                        bit_idx <= 3'd7;
                        state   <= din_eop ? DIV : ACCUM;
                    end else begin
                        if (div_ge) begin
                            sum <= sum - div_sub;
                        end
                        quo[bit_idx] <= div_ge;
                        if (bit_idx == 3'd0) begin
                            state <= LOAD;
                            busy  <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                end
                LOAD: begin
                    th_out <= cfg_auto ? auto_th : cfg_th;
                    th_upd <= 1'b1;
                    // A too-early sop is still captured rather than silently dropped.
                    if (frame_start) begin
                        sum     <= {{CNT_W{1'b0}}, din};
                        cnt     <= CNT_W'(1);
                        bit_idx <= 3'd7;
                        state   <= din_eop ? DIV : ACCUM;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_th_ctrl.sv
// Directed self-checking bench for bin_th_ctrl: three instances with TH_OFS 0, -20 and +100
// share one stimulus stream so offset and saturation are checked alongside the plain mean.
module tb_bin_th_ctrl;

    logic       clk;
    logic       rst_n;
    logic       din_sop;
    logic       din_eop;
    logic       din_vld;
    logic [7:0] din;
    logic       cfg_auto;
    logic [7:0] cfg_th;

    logic [7:0] th_out0, th_outm, th_outp;
    logic       th_upd0, th_updm, th_updp;
    logic       busy0, busym, busyp;
    logic       seq_err0, seq_errm, seq_errp;

    int errors = 0;
    int checks = 0;

    logic [7:0] th0, thm, thp;

`ifdef BIN_TH_IIR_EN
    localparam bit IIR = 1'b1;
`else
    localparam bit IIR = 1'b0;
`endif

    bin_th_ctrl #(.CNT_W(20), .TH_INIT(8'd100), .TH_OFS(9'sd0)) dut (
        .clk(clk), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
        .din(din), .cfg_auto(cfg_auto), .cfg_th(cfg_th), .th_out(th_out0), .th_upd(th_upd0),
        .busy(busy0), .seq_err(seq_err0)
    );

    bin_th_ctrl #(.CNT_W(20), .TH_INIT(8'd100), .TH_OFS(-9'sd20)) dut_m20 (
        .clk(clk), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
        .din(din), .cfg_auto(cfg_auto), .cfg_th(cfg_th), .th_out(th_outm), .th_upd(th_updm),
        .busy(busym), .seq_err(seq_errm)
    );

    bin_th_ctrl #(.CNT_W(20), .TH_INIT(8'd100), .TH_OFS(9'sd100)) dut_p100 (
        .clk(clk), .rst_n(rst_n), .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld),
        .din(din), .cfg_auto(cfg_auto), .cfg_th(cfg_th), .th_out(th_outp), .th_upd(th_updp),
        .busy(busyp), .seq_err(seq_errp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_auto(input logic [7:0] prev, input logic [7:0] s);
        logic [9:0] t;
        t = {2'b00, prev} * 10'd3 + {2'b00, s};
        return IIR ? t[9:2] : s;
    endfunction

    task automatic check_output(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one beat and advances past the next rising edge; outputs are then settled.
    task automatic apply_stimulus(input logic sop, input logic eop, input logic vld, input logic [7:0] d);
        din_sop = sop;
        din_eop = eop;
        din_vld = vld;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
        apply_stimulus(1'b1, 1'b0, 1'b1, p0);
        apply_stimulus(1'b0, 1'b0, 1'b1, p1);
        apply_stimulus(1'b0, 1'b0, 1'b1, p2);
        apply_stimulus(1'b0, 1'b1, 1'b1, p3);
    endtask

    // Called right after the eop edge; s* are the saturated means, or the manual value.
    task automatic expect_load(input string tag, input logic manual,
                               input logic [7:0] s0, input logic [7:0] sm, input logic [7:0] sp);
        logic [7:0] e0, em, ep;
        e0 = manual ? s0 : exp_auto(th0, s0);
        em = manual ? sm : exp_auto(thm, sm);
        ep = manual ? sp : exp_auto(thp, sp);
        check_output({tag, "_busy_div"}, {8'd0, busy0}, 9'd1);
        idle(8);
        check_output({tag, "_hold"}, {1'b0, th_out0}, {1'b0, th0});
        check_output({tag, "_upd_early"}, {8'd0, th_upd0}, 9'd0);
        idle(1);
        check_output({tag, "_th0"}, {1'b0, th_out0}, {1'b0, e0});
        check_output({tag, "_thm20"}, {1'b0, th_outm}, {1'b0, em});
        check_output({tag, "_thp100"}, {1'b0, th_outp}, {1'b0, ep});
        check_output({tag, "_upd"}, {8'd0, th_upd0}, 9'd1);
        check_output({tag, "_busy_load"}, {8'd0, busy0}, 9'd0);
        idle(1);
        check_output({tag, "_upd_once"}, {8'd0, th_upd0}, 9'd0);
        th0 = e0;
        thm = em;
        thp = ep;
        idle(2);
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_auto = 1'b1;
        cfg_th   = 8'd0;
        din_sop  = 1'b0;
        din_eop  = 1'b0;
        din_vld  = 1'b0;
        din      = 8'd0;
        th0 = 8'd100;
        thm = 8'd100;
        thp = 8'd100;
        idle(2);
        check_output("rst_th0", {1'b0, th_out0}, 9'd100);
        check_output("rst_thp", {1'b0, th_outp}, 9'd100);
        check_output("rst_upd", {8'd0, th_upd0}, 9'd0);
        check_output("rst_busy", {8'd0, busy0}, 9'd0);
        check_output("rst_err", {8'd0, seq_err0}, 9'd0);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] eop in IDLE is ignored");
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'd33);
        check_output("lone_eop_busy", {8'd0, busy0}, 9'd0);
        check_output("lone_eop_err", {8'd0, seq_err0}, 9'd0);
        idle(2);

        $display("[TB] frame of 200s: mean 200, -20 -> 180, +100 -> 255");
        send_frame(8'd200, 8'd200, 8'd200, 8'd200);
        expect_load("t1", 1'b0, 8'd200, 8'd180, 8'd255);
        idle(10);

        $display("[TB] frame 0,255,0,255 with an invalid beat inside: 510/4 = 127");
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd0);
        check_output("t2_busy_accum", {8'd0, busy0}, 9'd1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'd255);
        check_output("t2_novld_err", {8'd0, seq_err0}, 9'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd255);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'd255);
        expect_load("t2", 1'b0, 8'd127, 8'd107, 8'd227);
        idle(10);

        $display("[TB] frame of 10s: -20 saturates to 0");
        send_frame(8'd10, 8'd10, 8'd10, 8'd10);
        expect_load("t3", 1'b0, 8'd10, 8'd0, 8'd110);
        idle(10);

        $display("[TB] sop during DIV aborts; restarted frame of 60s");
        send_frame(8'd30, 8'd30, 8'd30, 8'd30);
        idle(2);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd60);
        check_output("t4_abort_err", {8'd0, seq_err0}, 9'd1);
        check_output("t4_abort_busy", {8'd0, busy0}, 9'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd60);
        check_output("t4_err_pulse", {8'd0, seq_err0}, 9'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd60);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'd60);
        check_output("t4_no_upd", {8'd0, th_upd0}, 9'd0);
        check_output("t4_th_kept", {1'b0, th_out0}, {1'b0, th0});
        expect_load("t4", 1'b0, 8'd60, 8'd40, 8'd160);
        idle(10);

        $display("[TB] manual mode selected mid-frame, then sop without eop");
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd90);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd90);
        cfg_auto = 1'b0;
        cfg_th   = 8'd50;
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd90);
        check_output("t5_mid_hold", {1'b0, th_out0}, {1'b0, th0});
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'd90);
        expect_load("t5", 1'b1, 8'd50, 8'd50, 8'd50);
        idle(10);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd5);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd5);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd5);
        check_output("t5_sop_no_eop_err", {8'd0, seq_err0}, 9'd1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'd5);
        check_output("t5_err_clear", {8'd0, seq_err0}, 9'd0);
        cfg_th = 8'd77;
        expect_load("t5b", 1'b1, 8'd77, 8'd77, 8'd77);
        idle(10);

        $display("[TB] auto again, mean 7/4 truncates to 1");
        cfg_auto = 1'b1;
        send_frame(8'd1, 8'd2, 8'd2, 8'd2);
        expect_load("t6", 1'b0, 8'd1, 8'd0, 8'd101);
        idle(10);

        $display("[TB] async reset mid-frame");
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd40);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'd40);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t7_rst_busy", {8'd0, busy0}, 9'd0);
        check_output("t7_rst_th", {1'b0, th_outm}, 9'd100);
        idle(1);
        rst_n = 1'b1;
        th0 = 8'd100;
        thm = 8'd100;
        thp = 8'd100;
        idle(2);
        send_frame(8'd200, 8'd200, 8'd200, 8'd200);
        expect_load("t8", 1'b0, 8'd200, 8'd180, 8'd255);
        idle(10);
        send_frame(8'd200, 8'd200, 8'd200, 8'd200);
        expect_load("t8b", 1'b0, 8'd200, 8'd180, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
